// File: rtl/memaccess.sv
// Memory-access pipeline stage: forwards execute results to writeback and performs
// one data-memory load or store per instruction, with an alignment check and an ack timeout.
module memaccess #(
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned DW = 32,
  localparam int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [RW-1:0] rd_num,
  input  logic [DW-1:0] md,
  input  logic [DW-1:0] result,
  input  logic [DW-1:0] cpsr_in,
  input  logic          taken,
  input  logic          is_alu_op,
  input  logic          is_cmp_op,
  input  logic          is_jmp_op,
  input  logic          is_ld_op,
  input  logic          is_str_op,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic [RW-1:0] rd_num_passthrough,
  output logic [DW-1:0] md_passthrough,
  output logic [DW-1:0] result_passthrough,
  output logic [DW-1:0] cpsr_out,
  output logic [DW-1:0] dmem_val_passthrough,
  output logic          taken_out,
  output logic          is_alu_op_passthrough,
  output logic          is_cmp_op_passthrough,
  output logic          is_jmp_op_passthrough,
  output logic          is_ld_op_passthrough,
  output logic          mem_fault
);

  localparam int unsigned CW        = 8;
  localparam int unsigned CNT_EXT_W = CW + 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  typedef struct packed {
    logic [RW-1:0] rd_num;
    logic [DW-1:0] md;
    logic [DW-1:0] result;
    logic [DW-1:0] cpsr;
    logic          taken;
    logic          is_ld;
    logic          is_str;
  } operand_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  operand_t        op_q, op_in, wb_src;
  logic            capture;
  logic            wb_en;
  logic            wb_from_in;
  logic            wb_ld_hit;
  logic            timeout_hit;
  logic            alu_pt_d, cmp_pt_d, jmp_pt_d, fault_d;

  always_comb begin
    op_in.rd_num = rd_num;
    op_in.md     = md;
    op_in.result = result;
    op_in.cpsr   = cpsr_in;
    op_in.taken  = taken;
    op_in.is_ld  = is_ld_op;
    op_in.is_str = is_str_op;
  end

  // Next-state, writeback control and stall.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    capture     = 1'b0;
    wb_en       = 1'b0;
    wb_from_in  = 1'b0;
    wb_ld_hit   = 1'b0;
    timeout_hit = 1'b0;
    alu_pt_d    = 1'b0;
    cmp_pt_d    = 1'b0;
    jmp_pt_d    = 1'b0;
    fault_d     = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          capture = 1'b1;
          if (is_ld_op || is_str_op) begin
            if (result[1:0] == 2'b00) begin
              state_d    = ACCESS;
              wait_cnt_d = '0;
            end else begin
              wb_en      = 1'b1;
              wb_from_in = 1'b1;
              fault_d    = 1'b1;
            end
          end else begin
            wb_en      = 1'b1;
            wb_from_in = 1'b1;
            alu_pt_d   = is_alu_op;
            cmp_pt_d   = is_cmp_op;
            jmp_pt_d   = is_jmp_op;
          end
        end
      end
      ACCESS: begin
        // An ack in the final counted cycle wins over the timeout.
        timeout_hit = (CNT_EXT_W'(wait_cnt_q) + CNT_EXT_W'(1)) == CNT_EXT_W'(TIMEOUT);
        if (dmem_ack) begin
          state_d   = IDLE;
          wb_en     = 1'b1;
          wb_ld_hit = op_q.is_ld;
        end else if (timeout_hit) begin
          state_d = IDLE;
          wb_en   = 1'b1;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CW'(1);
          stall      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb wb_src = wb_from_in ? op_in : op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      op_q       <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (capture) op_q <= op_in;
    end
  end

  // Writeback registers: data holds between updates, flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_num_passthrough    <= '0;
      md_passthrough        <= '0;
      result_passthrough    <= '0;
      cpsr_out              <= '0;
      taken_out             <= 1'b0;
      dmem_val_passthrough  <= '0;
      is_alu_op_passthrough <= 1'b0;
      is_cmp_op_passthrough <= 1'b0;
      is_jmp_op_passthrough <= 1'b0;
      is_ld_op_passthrough  <= 1'b0;
      mem_fault             <= 1'b0;
    end else begin
      if (wb_en) begin
        rd_num_passthrough <= wb_src.rd_num;
        md_passthrough     <= wb_src.md;
        result_passthrough <= wb_src.result;
        cpsr_out           <= wb_src.cpsr;
        taken_out          <= wb_src.taken;
      end
      if (wb_ld_hit) dmem_val_passthrough <= dmem_rdata;
      is_alu_op_passthrough <= alu_pt_d;
      is_cmp_op_passthrough <= cmp_pt_d;
      is_jmp_op_passthrough <= jmp_pt_d;
      is_ld_op_passthrough  <= wb_ld_hit;
      mem_fault             <= fault_d;
    end
  end

  // Request fields come straight from the captured operands so they stay stable.
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = dmem_req & op_q.is_str;
  assign dmem_addr  = op_q.result;
  assign dmem_wdata = op_q.md;

endmodule

// File: tb/tb_memaccess.sv
// Bench for memaccess: directed scenarios followed by random instructions,
// checked against a transaction-level model of the stage's writeback results.
module tb_memaccess;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, taken;
  logic [3:0]  rd_num;
  logic [31:0] md, result, cpsr_in;
  logic        is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op;
  logic        stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  rd_num_passthrough;
  logic [31:0] md_passthrough, result_passthrough, cpsr_out, dmem_val_passthrough;
  logic        taken_out, is_alu_op_passthrough, is_cmp_op_passthrough;
  logic        is_jmp_op_passthrough, is_ld_op_passthrough, mem_fault;

  always #5 clk = ~clk;

  memaccess #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid),
    .rd_num(rd_num), .md(md), .result(result), .cpsr_in(cpsr_in), .taken(taken),
    .is_alu_op(is_alu_op), .is_cmp_op(is_cmp_op), .is_jmp_op(is_jmp_op),
    .is_ld_op(is_ld_op), .is_str_op(is_str_op),
    .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .rd_num_passthrough(rd_num_passthrough), .md_passthrough(md_passthrough),
    .result_passthrough(result_passthrough), .cpsr_out(cpsr_out),
    .dmem_val_passthrough(dmem_val_passthrough), .taken_out(taken_out),
    .is_alu_op_passthrough(is_alu_op_passthrough), .is_cmp_op_passthrough(is_cmp_op_passthrough),
    .is_jmp_op_passthrough(is_jmp_op_passthrough), .is_ld_op_passthrough(is_ld_op_passthrough),
    .mem_fault(mem_fault)
  );

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] md;
    logic [31:0] res;
    logic [31:0] cpsr;
    logic        taken;
    logic        alu, cmp, jmp, ld, str;
  } ins_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected writeback state.
  logic [3:0]  exp_rd;
  logic [31:0] exp_md, exp_res, exp_cpsr, exp_dval;
  logic        exp_taken, exp_alu, exp_cmp, exp_jmp, exp_ld, exp_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, "/rd"},    32'(rd_num_passthrough),   32'(exp_rd));
    chk({tag, "/md"},    md_passthrough,            exp_md);
    chk({tag, "/res"},   result_passthrough,        exp_res);
    chk({tag, "/cpsr"},  cpsr_out,                  exp_cpsr);
    chk({tag, "/taken"}, 32'(taken_out),            32'(exp_taken));
    chk({tag, "/dval"},  dmem_val_passthrough,      exp_dval);
    chk({tag, "/alu"},   32'(is_alu_op_passthrough), 32'(exp_alu));
    chk({tag, "/cmp"},   32'(is_cmp_op_passthrough), 32'(exp_cmp));
    chk({tag, "/jmp"},   32'(is_jmp_op_passthrough), 32'(exp_jmp));
    chk({tag, "/ld"},    32'(is_ld_op_passthrough),  32'(exp_ld));
    chk({tag, "/fault"}, 32'(mem_fault),            32'(exp_fault));
  endtask

  task automatic model_clear();
    exp_rd = '0; exp_md = '0; exp_res = '0; exp_cpsr = '0; exp_dval = '0;
    exp_taken = 1'b0; exp_alu = 1'b0; exp_cmp = 1'b0; exp_jmp = 1'b0;
    exp_ld = 1'b0; exp_fault = 1'b0;
  endtask

  task automatic model_data(input ins_t ins);
    exp_rd = ins.rd; exp_md = ins.md; exp_res = ins.res;
    exp_cpsr = ins.cpsr; exp_taken = ins.taken;
    exp_alu = 1'b0; exp_cmp = 1'b0; exp_jmp = 1'b0; exp_ld = 1'b0; exp_fault = 1'b0;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0;
    rd_num = 4'($urandom); md = $urandom; result = $urandom; cpsr_in = $urandom;
    taken = 1'($urandom); is_alu_op = 1'($urandom); is_cmp_op = 1'($urandom);
    is_jmp_op = 1'($urandom); is_ld_op = 1'($urandom); is_str_op = 1'($urandom);
  endtask

  // Idle cycle with random ack noise: flags drop, data holds, no request.
  task automatic idle_cycle(input string tag);
    scramble_inputs();
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    tick();
    exp_alu = 1'b0; exp_cmp = 1'b0; exp_jmp = 1'b0; exp_ld = 1'b0; exp_fault = 1'b0;
    chk_wb({tag, "/idle"});
    chk({tag, "/idle_req"},   32'(dmem_req), 32'd0);
    chk({tag, "/idle_stall"}, 32'(stall),    32'd0);
    dmem_ack = 1'b0;
  endtask

  // ack_at: ACCESS cycle (1-based) in which ack is given; 0 means never.
  task automatic run_instr(input ins_t ins, input int ack_at, input logic [31:0] rdata,
                           input string tag);
    logic mem_op, aligned, success;
    mem_op  = ins.ld | ins.str;
    aligned = (ins.res[1:0] == 2'b00);
    in_valid = 1'b1;
    rd_num = ins.rd; md = ins.md; result = ins.res; cpsr_in = ins.cpsr; taken = ins.taken;
    is_alu_op = ins.alu; is_cmp_op = ins.cmp; is_jmp_op = ins.jmp;
    is_ld_op = ins.ld; is_str_op = ins.str;
    dmem_ack = 1'b0;
    #1;
    chk({tag, "/accept_stall"}, 32'(stall), 32'd0);
    tick();
    scramble_inputs();
    if (!mem_op || !aligned) begin
      model_data(ins);
      if (mem_op) exp_fault = 1'b1;
      else begin
        exp_alu = ins.alu; exp_cmp = ins.cmp; exp_jmp = ins.jmp;
      end
      chk_wb(tag);
      chk({tag, "/noreq"}, 32'(dmem_req), 32'd0);
    end else begin
      for (int n = 1; n <= int'(TO); n++) begin
        dmem_ack = (n == ack_at);
        dmem_rdata = rdata;
        #1;
        chk({tag, "/req"},   32'(dmem_req),  32'd1);
        chk({tag, "/addr"},  dmem_addr,      ins.res);
        chk({tag, "/we"},    32'(dmem_we),   32'(ins.str));
        chk({tag, "/wdata"}, dmem_wdata,     ins.md);
        chk({tag, "/stall"}, 32'(stall),     32'((n != ack_at) && (n != int'(TO))));
        tick();
        if (n == ack_at) break;
      end
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      #1;
      success = (ack_at >= 1) && (ack_at <= int'(TO));
      model_data(ins);
      if (success) begin
        if (ins.ld) begin
          exp_dval = rdata;
          exp_ld   = 1'b1;
        end
      end else begin
        exp_fault = 1'b1;
      end
      chk_wb(tag);
      chk({tag, "/done_req"},   32'(dmem_req), 32'd0);
      chk({tag, "/done_stall"}, 32'(stall),    32'd0);
    end
    idle_cycle(tag);
  endtask

  function automatic ins_t mk(input int cls, input logic [31:0] res, input logic [31:0] mdv,
                              input logic [3:0] rd);
    ins_t i;
    i.rd = rd; i.md = mdv; i.res = res; i.cpsr = $urandom; i.taken = 1'($urandom);
    i.alu = (cls == 0); i.cmp = (cls == 1); i.jmp = (cls == 2);
    i.ld = (cls == 3); i.str = (cls == 4);
    return i;
  endfunction

  function automatic ins_t rand_ins();
    ins_t i;
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
    i = mk(int'($urandom_range(0, 4)), r, $urandom, 4'($urandom));
    return i;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ins_t ins;
    reset = 1'b1;
    scramble_inputs();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    tick();
    dmem_ack = 1'b0;
    #1;
    model_clear();
    chk_wb("reset");
    chk("reset/req",   32'(dmem_req), 32'd0);
    chk("reset/we",    32'(dmem_we),  32'd0);
    chk("reset/addr",  dmem_addr,     32'd0);
    chk("reset/wdata", dmem_wdata,    32'd0);
    chk("reset/stall", 32'(stall),    32'd0);
    reset = 1'b0;

    run_instr(mk(0, 32'h11, 32'h0, 4'd3), 0, 32'h0, "alu");
    run_instr(mk(1, 32'h8000_0000, 32'h1234, 4'd7), 0, 32'h0, "cmp");
    run_instr(mk(2, 32'h44, 32'h0000_2000, 4'd15), 0, 32'h0, "jmp");
    run_instr(mk(3, 32'h100, 32'h0, 4'd1), 3, 32'hDEAD_BEEF, "ld_ack3");
    run_instr(mk(4, 32'h104, 32'h55, 4'd2), 2, 32'hCAFE_0000, "str_ack2");
    run_instr(mk(3, 32'h102, 32'h0, 4'd4), 1, 32'h0, "ld_misalign");
    run_instr(mk(4, 32'h107, 32'h99, 4'd5), 1, 32'h0, "str_misalign");
    run_instr(mk(3, 32'h200, 32'h0, 4'd6), 0, 32'h0, "ld_timeout");
    run_instr(mk(3, 32'h204, 32'h0, 4'd6), 1, 32'h0BAD_F00D, "ld_after_to");
    run_instr(mk(3, 32'h208, 32'h0, 4'd8), int'(TO), 32'h1357_9BDF, "ld_ack_at_to");
    run_instr(mk(4, 32'h20C, 32'h77, 4'd9), 0, 32'h0, "str_timeout");

    // Reset while a load is outstanding.
    ins = mk(3, 32'h300, 32'hAAAA_5555, 4'd10);
    in_valid = 1'b1;
    rd_num = ins.rd; md = ins.md; result = ins.res; cpsr_in = ins.cpsr; taken = ins.taken;
    is_alu_op = 1'b0; is_cmp_op = 1'b0; is_jmp_op = 1'b0; is_ld_op = 1'b1; is_str_op = 1'b0;
    tick();
    scramble_inputs();
    #1;
    chk("rst_mid/req_before", 32'(dmem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    model_clear();
    chk_wb("rst_mid");
    chk("rst_mid/req",   32'(dmem_req), 32'd0);
    chk("rst_mid/stall", 32'(stall),    32'd0);
    chk("rst_mid/addr",  dmem_addr,     32'd0);
    chk("rst_mid/we",    32'(dmem_we),  32'd0);
    idle_cycle("rst_mid");

    for (int k = 0; k < 40; k++) begin
      run_instr(rand_ins(), int'($urandom_range(0, TO)), $urandom, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
